mem_dbus_ctrl: RTL
==================

Name: mem_dbus_ctrl

Overview:
Memory-access stage controller that consumes the EX/MEM pipeline register outputs and drives the data-memory bus with a req/ack handshake.
Decodes load/store ops, generates byte enables and lane-replicated store data, and sign/zero-extends load results.
Raises a stall request into the stall controller while an access is outstanding.
Handles flush mid-access and a bus timeout.

Parameters:
OP_LB, 8'h90, aluop code for load byte signed
OP_LBU, 8'h91, load byte unsigned
OP_LH, 8'h92, load half signed
OP_LHU, 8'h93, load half unsigned
OP_LW, 8'h94, load word
OP_SB, 8'h98, store byte
OP_SH, 8'h99, store half
OP_SW, 8'h9A, store word
EXC_NONE, 5'h1F, exccode value meaning "no exception"
TIMEOUT, 255, max cycles in REQ without ack (1..2^CNT_W-1)
CNT_W, 8, timeout counter width

Ports:
cpu_clk_50M  in  1  clock
cpu_rst_n  in  1  reset, asynchronous, active-low
mem_aluop  in  8  op from EX/MEM register
mem_wd  in  32  effective address for load/store
mem_din  in  32  store data (low bits significant)
mem_exccode  in  5  pending exception of the MEM instruction
flush  in  1  exception flush
wb_stall  in  1  later stage stalled (stall[4])
dbus_req  out  1  bus request, held until ack
dbus_we  out  1  1 = store
dbus_be  out  4  byte enables, bit i = byte i (little-endian)
dbus_addr  out  32  word address {mem_wd[31:2],2'b00}
dbus_wdata  out  32  lane-replicated store data
dbus_rdata  in  32  read data, valid with ack
dbus_ack  in  1  single-cycle acknowledge
stall_request_mem  out  1  stall request to stall controller (combinational)
mem_load_data  out  32  formatted load result
mem_bus_err  out  1  timeout flag for current access

Behaviour:
- pending = mem_aluop is one of the 8 codes & mem_exccode==EXC_NONE & ~flush.
- States: IDLE, REQ, DONE, DRAIN. Reset (async): state=IDLE.
- Reset values: all bus outputs 0, mem_load_data=0, mem_bus_err=0, timeout counter 0.
- Registered bus outputs; they are held constant while dbus_req=1.
- IDLE:
  - pending -> register req=1, we, be, addr, wdata; counter=0; go REQ.
- REQ:
  - counter increments every cycle.
  - flush -> go DRAIN with req still high.
  - dbus_ack -> req=0, we=0, be=0. For loads, mem_load_data=formatted rdata. mem_bus_err=0. Go DONE.
  - counter==TIMEOUT-1 with no ack -> req=0, mem_bus_err=1, mem_load_data unchanged, go DONE.
- DONE:
  - Result is presented for this cycle.
  - wb_stall=1 -> stay DONE.
  - Otherwise go IDLE. mem_load_data and mem_bus_err hold until the next access completes.
  - flush in DONE -> IDLE.
- DRAIN:
  - Keep req until ack or timeout, discard data, go IDLE.
  - A new pending op waits in DRAIN and is issued from IDLE.
- stall_request_mem:
  - = pending & (state==IDLE | REQ | DRAIN).
  - 0 in DONE so the pipeline advances.
  - 0 whenever flush=1.
- Byte enables (a = mem_wd[1:0]):
  - SB: be=1<<a, wdata={4{din[7:0]}}.
  - SH: be = a[1] ? 4'b1100 : 4'b0011, wdata={2{din[15:0]}}.
  - SW: be=4'b1111, wdata=din.
  - Loads: we=0, be as for the equivalent store size.
- Load formatting:
  - LB/LBU select byte a, sign- or zero-extend.
  - LH/LHU select half a[1], sign- or zero-extend.
  - LW passes rdata through.
- Alignment is checked upstream; a misaligned op arrives with a nonzero exccode and is never issued.
- Ack outside REQ/DRAIN is ignored.
- Async reset mid-access: immediately IDLE, req=0. The bus slave must tolerate an abandoned request.

Test Plan:
- LW at 0x0000_1004, ack after 3 cycles with rdata=0xDEADBEEF -> req high 3 cycles, be=4'hF, addr=0x1004; stall_request_mem=1 for 4 cycles, then 0 in DONE; mem_load_data=0xDEADBEEF.
- LB addr 0x...03, rdata=0x80_11_22_33 -> be=4'b1000, mem_load_data=0xFFFFFF80; LBU same -> 0x00000080.
- SH addr 0x...02, din=0x0000ABCD -> we=1, be=4'b1100, wdata=0xABCDABCD; ack next cycle -> DONE, no load-data change.
- Flush asserted 1 cycle into an LW -> req stays high until ack; data discarded, load_data unchanged; back-to-back SW waits and issues only after DRAIN completes.
- Never ack with TIMEOUT=4 -> req drops after 4 REQ cycles, mem_bus_err=1, stall_request_mem=0 in DONE.
- mem_exccode!=EXC_NONE with OP_LW -> no req, stall_request_mem=0. wb_stall=1 during DONE holds DONE and mem_load_data stable.

Source files
------------

// File: rtl/mem_dbus_ctrl.sv
// Memory-access stage data-bus controller.
// Issues EX/MEM loads/stores on a req/ack bus and formats load results.
module mem_dbus_ctrl #(
   parameter logic [7:0] OP_LB    = 8'h90,
   parameter logic [7:0] OP_LBU   = 8'h91,
   parameter logic [7:0] OP_LH    = 8'h92,
   parameter logic [7:0] OP_LHU   = 8'h93,
   parameter logic [7:0] OP_LW    = 8'h94,
   parameter logic [7:0] OP_SB    = 8'h98,
   parameter logic [7:0] OP_SH    = 8'h99,
   parameter logic [7:0] OP_SW    = 8'h9A,
   parameter logic [4:0] EXC_NONE = 5'h1F,
   parameter int         TIMEOUT  = 255,
   parameter int         CNT_W    = 8
) (
   input  logic        cpu_clk_50M,
   input  logic        cpu_rst_n,
   input  logic [7:0]  mem_aluop,
   input  logic [31:0] mem_wd,
   input  logic [31:0] mem_din,
   input  logic [4:0]  mem_exccode,
   input  logic        flush,
   input  logic        wb_stall,
   output logic        dbus_req,
   output logic        dbus_we,
   output logic [3:0]  dbus_be,
   output logic [31:0] dbus_addr,
   output logic [31:0] dbus_wdata,
   input  logic [31:0] dbus_rdata,
   input  logic        dbus_ack,
   output logic        stall_request_mem,
   output logic [31:0] mem_load_data,
   output logic        mem_bus_err
);

   typedef enum logic [1:0] {IDLE, REQ, DONE, DRAIN} state_t;

   state_t           state;
   state_t           state_nx;
   logic [CNT_W-1:0] cnt;
   logic             is_ld;
   logic             is_st;
   logic             pending;
   logic             tmo;
   logic             issue;
   logic             busy;
   logic             drop;
   logic             finish;
   logic [1:0]       a;
   logic [3:0]       be_nx;
   logic [31:0]      wdata_nx;
   logic [7:0]       op_q;
   logic [1:0]       off_q;
   logic             ld_q;
   logic [7:0]       byte_v;
   logic [15:0]      half_v;
   logic [31:0]      fmt;

   assign a   = mem_wd[1:0];
   assign tmo = (cnt == CNT_W'(TIMEOUT - 1));

   // Decode op class, byte enables and lane-replicated store data
   always_comb begin
      is_ld    = 1'b0;
      is_st    = 1'b0;
      be_nx    = 4'b0000;
      wdata_nx = mem_din;
      case (mem_aluop)
         OP_LB, OP_LBU: begin
            is_ld = 1'b1;
            be_nx = 4'b0001 << a;
         end
         OP_LH, OP_LHU: begin
            is_ld = 1'b1;
            be_nx = a[1] ? 4'b1100 : 4'b0011;
         end
         OP_LW: begin
            is_ld = 1'b1;
            be_nx = 4'b1111;
         end
         OP_SB: begin
            is_st    = 1'b1;
            be_nx    = 4'b0001 << a;
            wdata_nx = {4{mem_din[7:0]}};
         end
         OP_SH: begin
            is_st    = 1'b1;
            be_nx    = a[1] ? 4'b1100 : 4'b0011;
            wdata_nx = {2{mem_din[15:0]}};
         end
         OP_SW: begin
            is_st = 1'b1;
            be_nx = 4'b1111;
         end
         default: ;
      endcase
   end

   assign pending = (is_ld | is_st) & (mem_exccode == EXC_NONE) & ~flush;

   // Select and extend the addressed lane of the returned word
   always_comb begin
      byte_v = 8'(dbus_rdata >> {off_q, 3'b000});
      half_v = off_q[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];
      fmt    = dbus_rdata;
      case (op_q)
         OP_LB:   fmt = {{24{byte_v[7]}}, byte_v};
         OP_LBU:  fmt = {24'h0, byte_v};
         OP_LH:   fmt = {{16{half_v[15]}}, half_v};
         OP_LHU:  fmt = {16'h0, half_v};
         default: fmt = dbus_rdata;
      endcase
   end

   // State register
   always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
      if (!cpu_rst_n) state <= IDLE;
      else            state <= state_nx;
   end

   // Next-state logic; a flush that coincides with ack or timeout needs no drain
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
            if (pending) state_nx = REQ;
         end
         REQ: begin
            if (flush)
               state_nx = (dbus_ack | tmo) ? IDLE : DRAIN;
            else if (dbus_ack | tmo)
               state_nx = DONE;
         end
         DONE: begin
            if (flush | ~wb_stall) state_nx = IDLE;
         end
         DRAIN: begin
            if (dbus_ack | tmo) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Control strobes and the combinational stall request
   always_comb begin
      issue  = (state == IDLE) & pending;
      busy   = (state == REQ) | (state == DRAIN);
      drop   = busy & (dbus_ack | tmo);
      finish = (state == REQ) & ~flush & (dbus_ack | tmo);
      stall_request_mem = pending & (state != DONE);
   end

   // Registered bus outputs, timeout counter and result capture
   always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
      if (!cpu_rst_n) begin
         dbus_req      <= 1'b0;
         dbus_we       <= 1'b0;
         dbus_be       <= 4'b0000;
         dbus_addr     <= 32'h0;
         dbus_wdata    <= 32'h0;
         cnt           <= '0;
         op_q          <= 8'h0;
         off_q         <= 2'b00;
         ld_q          <= 1'b0;
         mem_load_data <= 32'h0;
         mem_bus_err   <= 1'b0;
      end else begin
         if (issue) begin
            dbus_req   <= 1'b1;
            dbus_we    <= is_st;
            dbus_be    <= be_nx;
            dbus_addr  <= {mem_wd[31:2], 2'b00};
            dbus_wdata <= wdata_nx;
            cnt        <= '0;
            op_q       <= mem_aluop;
            off_q      <= a;
            ld_q       <= is_ld;
         end else if (busy) begin
            cnt <= cnt + 1'b1;
            if (drop) begin
               dbus_req <= 1'b0;
               dbus_we  <= 1'b0;
               dbus_be  <= 4'b0000;
            end
         end
         if (finish) begin
            if (dbus_ack) begin
               mem_bus_err <= 1'b0;
               if (ld_q) mem_load_data <= fmt;
            end else begin
               mem_bus_err <= 1'b1;
            end
         end
      end
   end

endmodule
